// File: rtl/ets_check_sequencer.sv
// ets_check_sequencer: buffers retired-instruction timing events in a FIFO,
// looks up each event's signature, drives the timing comparator one event at
// a time, keeps saturating statistics and a sticky alert on repeated anomalies.
// Optional macro ETS_LOOKUP_TIMEOUT_EN adds a lookup timeout of TIMEOUT cycles.
// Handshake: an event transfers on a clock edge where evt_valid && evt_ready;
// sig_req is a level held until the cycle sig_valid is sampled high.
module ets_check_sequencer #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned CLASS_W      = 6,
  parameter int unsigned ALERT_THRESH = 4,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               monitor_enable,
  input  logic               evt_valid,
  output logic               evt_ready,
  input  logic [CLASS_W-1:0] evt_class,
  input  logic [31:0]        evt_cycles,
  output logic               sig_req,
  output logic [CLASS_W-1:0] sig_addr,
  input  logic               sig_valid,
  input  logic               sig_hit,
  output logic               cmp_enable,
  output logic [31:0]        cmp_actual,
  input  logic               cmp_anomaly,
  input  logic               cmp_too_slow,
  input  logic               cmp_too_fast,
  output logic               alert,
  input  logic               alert_clear,
  output logic [15:0]        anomaly_count,
  output logic [31:0]        checked_count,
  output logic [15:0]        miss_count,
  output logic               last_slow,
  output logic               last_fast,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [7:0] THRESH = 8'(ALERT_THRESH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOOKUP  = 2'd1,
    S_COMPARE = 2'd2,
    S_RESULT  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CLASS_W-1:0] fifo_cls_q [DEPTH];
  logic [31:0]        fifo_cyc_q [DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  logic               full, empty, push, pop;
  logic [CLASS_W-1:0] class_q;
  logic [31:0]        cycles_q;
  logic               result_fire, miss_fire, tmo_hit;
  logic [7:0]         consec_q, consec_d;
  logic               alert_q, alert_d;
  logic [15:0]        anomaly_q, miss_q;
  logic [31:0]        checked_q;
  logic               last_slow_q, last_fast_q;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // While disabled, events are swallowed so the core never stalls on us.
  assign evt_ready = monitor_enable ? !full : 1'b1;
  assign push      = monitor_enable && evt_valid && !full;
  assign pop       = monitor_enable && (state_q == S_IDLE) && !empty;

  // FIFO storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cls_q[wr_ptr_q[AW-1:0]] <= evt_class;
      fifo_cyc_q[wr_ptr_q[AW-1:0]] <= evt_cycles;
    end
  end

  // FIFO pointers; disabling the monitor flushes all queued events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (!monitor_enable) begin
      rd_ptr_q <= wr_ptr_q;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Holding registers for the event under check.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      class_q  <= '0;
      cycles_q <= '0;
    end else if (pop) begin
      class_q  <= fifo_cls_q[rd_ptr_q[AW-1:0]];
      cycles_q <= fifo_cyc_q[rd_ptr_q[AW-1:0]];
    end
  end

`ifdef ETS_LOOKUP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q;

  assign tmo_hit = (state_q == S_LOOKUP) && (timer_q == TMO_LAST);

  // Lookup timer: zero outside LOOKUP, counts LOOKUP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    timer_q <= '0;
    else if (state_q != S_LOOKUP)  timer_q <= '0;
    else if (!tmo_hit)             timer_q <= timer_q + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; sig_valid wins over a coincident timeout.
  always_comb begin
    state_d     = state_q;
    result_fire = 1'b0;
    miss_fire   = 1'b0;
    case (state_q)
      S_IDLE:    if (pop) state_d = S_LOOKUP;
      S_LOOKUP: begin
        if (sig_valid) begin
          if (sig_hit) begin
            state_d = S_COMPARE;
          end else begin
            state_d   = S_IDLE;
            miss_fire = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d   = S_IDLE;
          miss_fire = 1'b1;
        end
      end
      S_COMPARE: state_d = S_RESULT;
      S_RESULT: begin
        state_d     = S_IDLE;
        result_fire = 1'b1;
      end
      default:   state_d = S_IDLE;
    endcase
    // An in-flight event is abandoned without touching statistics.
    if (!monitor_enable) begin
      state_d     = S_IDLE;
      result_fire = 1'b0;
      miss_fire   = 1'b0;
    end
  end

  // Consecutive-anomaly tracking and sticky alert; setting beats clearing.
  always_comb begin
    consec_d = consec_q;
    alert_d  = alert_q;
    if (alert_clear) begin
      consec_d = '0;
      alert_d  = 1'b0;
    end
    if (result_fire) begin
      if (cmp_anomaly) begin
        consec_d = (consec_q == 8'hFF) ? consec_q : consec_q + 8'd1;
        if (consec_d >= THRESH) alert_d = 1'b1;
      end else begin
        consec_d = '0;
      end
    end
  end

  // Statistics registers, all saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec_q    <= '0;
      alert_q     <= 1'b0;
      anomaly_q   <= '0;
      checked_q   <= '0;
      miss_q      <= '0;
      last_slow_q <= 1'b0;
      last_fast_q <= 1'b0;
    end else begin
      consec_q <= consec_d;
      alert_q  <= alert_d;
      if (miss_fire && (miss_q != 16'hFFFF)) miss_q <= miss_q + 16'd1;
      if (result_fire) begin
        last_slow_q <= cmp_too_slow;
        last_fast_q <= cmp_too_fast;
        if (checked_q != 32'hFFFF_FFFF) checked_q <= checked_q + 32'd1;
        if (cmp_anomaly && (anomaly_q != 16'hFFFF)) anomaly_q <= anomaly_q + 16'd1;
      end
    end
  end

  assign sig_req       = (state_q == S_LOOKUP);
  assign sig_addr      = class_q;
  assign cmp_enable    = (state_q == S_COMPARE);
  assign cmp_actual    = cycles_q;
  assign alert         = alert_q;
  assign anomaly_count = anomaly_q;
  assign checked_count = checked_q;
  assign miss_count    = miss_q;
  assign last_slow     = last_slow_q;
  assign last_fast     = last_fast_q;
  assign busy          = (state_q != S_IDLE) || !empty;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ets_check_sequencer.sv
// Bench for ets_check_sequencer: table of single events with hand-computed
// statistics, then hand-written multi-cycle sequences (alert priority, FIFO
// fill under stalled lookups, disable flush, lookup wait/timeout).
module tb_ets_check_sequencer;
  localparam int THRESH = 4;

  logic        clk = 1'b0;
  logic        rst_n, monitor_enable, evt_valid, evt_ready;
  logic [5:0]  evt_class, sig_addr;
  logic [31:0] evt_cycles, cmp_actual, checked_count;
  logic        sig_req, sig_valid, sig_hit, cmp_enable;
  logic        cmp_anomaly, cmp_too_slow, cmp_too_fast, alert, alert_clear;
  logic [15:0] anomaly_count, miss_count;
  logic        last_slow, last_fast, busy;
  logic [1:0]  dbg_state;

  typedef struct {
    logic [5:0]  cls;
    logic [31:0] cyc;
    bit hit; bit anom; bit slow; bit fast;
    int lat;
  } evt_t;

  typedef struct {
    evt_t ev;
    int e_chk; int e_anom; int e_miss;
    bit e_slow; bit e_fast; bit e_alert;
  } vec_t;

  logic [37:0] exp_q[$];
  evt_t        rsp_q[$];
  vec_t        tbl[11];

  int n_vec = 0, n_err = 0, n_cmp_en = 0;
  bit stall = 1'b0, exp_cmp = 1'b0, clr_in_result = 1'b0;
  int m_chk = 0, m_anom = 0, m_miss = 0, m_consec = 0;
  bit m_slow = 1'b0, m_fast = 1'b0, m_alert = 1'b0;

  ets_check_sequencer dut (
    .clk(clk), .rst_n(rst_n), .monitor_enable(monitor_enable),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_class(evt_class),
    .evt_cycles(evt_cycles), .sig_req(sig_req), .sig_addr(sig_addr),
    .sig_valid(sig_valid), .sig_hit(sig_hit), .cmp_enable(cmp_enable),
    .cmp_actual(cmp_actual), .cmp_anomaly(cmp_anomaly),
    .cmp_too_slow(cmp_too_slow), .cmp_too_fast(cmp_too_fast), .alert(alert),
    .alert_clear(alert_clear), .anomaly_count(anomaly_count),
    .checked_count(checked_count), .miss_count(miss_count),
    .last_slow(last_slow), .last_fast(last_fast), .busy(busy),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  initial forever #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference statistics for one completed event.
  task automatic model(input evt_t e);
    if (e.hit) begin
      m_chk++;
      m_slow = e.slow;
      m_fast = e.fast;
      if (e.anom) begin
        m_anom++;
        if (m_consec < 255) m_consec++;
        if (m_consec >= THRESH) m_alert = 1'b1;
      end else begin
        m_consec = 0;
      end
    end else begin
      m_miss++;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_checked"}, checked_count, m_chk);
    check({tag, "_anomaly"}, {16'd0, anomaly_count}, m_anom);
    check({tag, "_miss"}, {16'd0, miss_count}, m_miss);
    check({tag, "_last_slow"}, {31'd0, last_slow}, {31'd0, m_slow});
    check({tag, "_last_fast"}, {31'd0, last_fast}, {31'd0, m_fast});
    check({tag, "_alert"}, {31'd0, alert}, {31'd0, m_alert});
  endtask

  // Offer one event for one cycle; acc reports whether it was taken.
  task automatic send_one(input evt_t e, output bit acc);
    @(negedge clk);
    evt_valid  = 1'b1;
    evt_class  = e.cls;
    evt_cycles = e.cyc;
    acc = evt_ready;
    if (acc && monitor_enable) begin
      exp_q.push_back({e.cls, e.cyc});
      rsp_q.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    evt_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_busy"}, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  function automatic evt_t rand_evt();
    evt_t e;
    e.cls  = 6'($urandom_range(0, 63));
    e.cyc  = $urandom;
    e.hit  = ($urandom_range(0, 3) != 0);
    e.anom = e.hit && ($urandom_range(0, 1) == 1);
    e.slow = e.anom && ($urandom_range(0, 1) == 1);
    e.fast = e.anom && !e.slow;
    e.lat  = $urandom_range(0, 3);
    return e;
  endfunction

  // Signature DB and comparator responder; also scoreboards request contents.
  initial begin : responder
    evt_t cur;
    logic [37:0] exp_v;
    bit req_seen = 1'b0, prev_en = 1'b0;
    int wait_cnt = 0, cmp_age = 3;
    cur = '{cls: '0, cyc: '0, hit: 1'b0, anom: 1'b0, slow: 1'b0, fast: 1'b0, lat: 0};
    forever begin
      @(negedge clk);
      sig_valid = 1'b0;
      if (cmp_age < 3) cmp_age++;
      if (cmp_age == 1 && clr_in_result) alert_clear = 1'b1;
      if (cmp_age == 2) begin
        cmp_anomaly  = 1'b0;
        cmp_too_slow = 1'b0;
        cmp_too_fast = 1'b0;
        if (clr_in_result) alert_clear = 1'b0;
      end
      if (cmp_enable) begin
        n_cmp_en++;
        check("cmp_enable_one_cycle", {31'd0, prev_en}, 32'd0);
        check("cmp_enable_after_hit", {31'd0, exp_cmp}, 32'd1);
        check("cmp_actual_compare", cmp_actual, cur.cyc);
        exp_cmp      = 1'b0;
        cmp_anomaly  = cur.anom;
        cmp_too_slow = cur.slow;
        cmp_too_fast = cur.fast;
        cmp_age      = 0;
      end
      prev_en = cmp_enable;
      if (!sig_req) begin
        req_seen = 1'b0;
      end else begin
        if (!req_seen) begin
          req_seen = 1'b1;
          if (rsp_q.size() == 0) begin
            check("req_without_event", 32'd1, 32'd0);
            cur.hit = 1'b0;
            cur.lat = 0;
          end else begin
            cur   = rsp_q.pop_front();
            exp_v = exp_q.pop_front();
            check("sig_addr", {26'd0, sig_addr}, {26'd0, exp_v[37:32]});
            check("cmp_actual_lookup", cmp_actual, exp_v[31:0]);
          end
          wait_cnt = cur.lat;
        end
        if (!stall) begin
          if (wait_cnt == 0) begin
            sig_valid = 1'b1;
            sig_hit   = cur.hit;
            exp_cmp   = cur.hit;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  initial begin : main
    bit   acc;
    int   accepted;
    evt_t e;

    tbl[0]  = '{'{6'd5,  32'd100,        1'b1, 1'b0, 1'b0, 1'b0, 2}, 1, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{'{6'd9,  32'd7,          1'b0, 1'b0, 1'b0, 1'b0, 1}, 1, 0, 1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{'{6'd63, 32'hFFFF_FFFF,  1'b1, 1'b1, 1'b1, 1'b0, 0}, 2, 1, 1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{'{6'd1,  32'd50,         1'b1, 1'b1, 1'b0, 1'b1, 3}, 3, 2, 1, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{'{6'd2,  32'd3000,       1'b1, 1'b0, 1'b0, 1'b0, 1}, 4, 2, 1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{'{6'd10, 32'd11,         1'b1, 1'b1, 1'b1, 1'b0, 0}, 5, 3, 1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{'{6'd11, 32'd12,         1'b1, 1'b1, 1'b1, 1'b0, 2}, 6, 4, 1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{'{6'd12, 32'd13,         1'b1, 1'b1, 1'b1, 1'b0, 1}, 7, 5, 1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{'{6'd13, 32'd14,         1'b1, 1'b1, 1'b1, 1'b0, 0}, 8, 6, 1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{'{6'd20, 32'd0,          1'b0, 1'b0, 1'b0, 1'b0, 2}, 8, 6, 2, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{'{6'd42, 32'd123456,     1'b1, 1'b0, 1'b0, 1'b0, 0}, 9, 6, 2, 1'b0, 1'b0, 1'b1};

    // Reset.
    rst_n = 1'b0; monitor_enable = 1'b1; evt_valid = 1'b0; evt_class = '0;
    evt_cycles = '0; sig_valid = 1'b0; sig_hit = 1'b0; cmp_anomaly = 1'b0;
    cmp_too_slow = 1'b0; cmp_too_fast = 1'b0; alert_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_evt_ready",  {31'd0, evt_ready},  32'd1);
    check("rst_sig_req",    {31'd0, sig_req},    32'd0);
    check("rst_sig_addr",   {26'd0, sig_addr},   32'd0);
    check("rst_cmp_enable", {31'd0, cmp_enable}, 32'd0);
    check("rst_cmp_actual", cmp_actual,          32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_state",      {30'd0, dbg_state},  32'd0);
    check_model("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one event at a time, statistics against hand-computed values.
    for (int i = 0; i < 11; i++) begin
      send_one(tbl[i].ev, acc);
      check($sformatf("tbl%0d_accept", i), {31'd0, acc}, 32'd1);
      drop_valid();
      drain($sformatf("tbl%0d", i));
      model(tbl[i].ev);
      check($sformatf("tbl%0d_checked", i), checked_count, tbl[i].e_chk);
      check($sformatf("tbl%0d_anomaly", i), {16'd0, anomaly_count}, tbl[i].e_anom);
      check($sformatf("tbl%0d_miss", i), {16'd0, miss_count}, tbl[i].e_miss);
      check($sformatf("tbl%0d_last_slow", i), {31'd0, last_slow}, {31'd0, tbl[i].e_slow});
      check($sformatf("tbl%0d_last_fast", i), {31'd0, last_fast}, {31'd0, tbl[i].e_fast});
      check($sformatf("tbl%0d_alert", i), {31'd0, alert}, {31'd0, tbl[i].e_alert});
    end

    // Plain alert_clear pulse.
    alert_clear = 1'b1;
    @(negedge clk);
    alert_clear = 1'b0;
    check("clear_alert", {31'd0, alert}, 32'd0);
    m_alert = 1'b0; m_consec = 0;

    // Three anomalies, then a fourth whose RESULT coincides with alert_clear.
    for (int i = 0; i < 4; i++) begin
      e = '{cls: 6'(30 + i), cyc: 32'(500 + i), hit: 1'b1, anom: 1'b1,
            slow: 1'b0, fast: 1'b1, lat: 1};
      clr_in_result = (i == 3);
      send_one(e, acc);
      drop_valid();
      drain("prio");
      model(e);
      check($sformatf("prio%0d_alert", i), {31'd0, alert}, {31'd0, (i == 3)});
    end
    clr_in_result = 1'b0;
    check_model("prio");
    alert_clear = 1'b1;
    @(negedge clk);
    alert_clear = 1'b0;
    @(negedge clk);
    check("prio_cleared", {31'd0, alert}, 32'd0);
    m_alert = 1'b0; m_consec = 0;

    // Burst of 10 with lookups stalled: 1 in LOOKUP plus 8 queued.
    stall = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      e = rand_evt();
      send_one(e, acc);
      if (!acc) break;
      accepted++;
      model(e);
    end
    drop_valid();
    check("burst_accepted", accepted, 32'd9);
    check("burst_full_ready", {31'd0, evt_ready}, 32'd0);
    check("burst_busy", {31'd0, busy}, 32'd1);
    stall = 1'b0;
    drain("burst");
    check_model("burst");
    check("burst_queue_empty", exp_q.size(), 32'd0);

    // Disable during LOOKUP with three events queued.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = '{cls: 6'(40 + i), cyc: 32'(900 + i), hit: 1'b1, anom: 1'b0,
            slow: 1'b0, fast: 1'b0, lat: 0};
      send_one(e, acc);
    end
    @(negedge clk);
    evt_valid = 1'b0;
    check("dis_sig_req_before", {31'd0, sig_req}, 32'd1);
    monitor_enable = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    @(negedge clk);
    stall = 1'b0;
    check("dis_sig_req", {31'd0, sig_req}, 32'd0);
    check("dis_busy", {31'd0, busy}, 32'd0);
    check("dis_ready", {31'd0, evt_ready}, 32'd1);
    check_model("dis");
    send_one(e, acc);
    check("dis_discard_ready", {31'd0, acc}, 32'd1);
    drop_valid();
    check("dis_discard_busy", {31'd0, busy}, 32'd0);
    monitor_enable = 1'b1;
    @(negedge clk);
    e = '{cls: 6'd7, cyc: 32'd77, hit: 1'b1, anom: 1'b0, slow: 1'b0, fast: 1'b0, lat: 1};
    send_one(e, acc);
    drop_valid();
    drain("reen");
    model(e);
    check_model("reen");

`ifdef ETS_LOOKUP_TIMEOUT_EN
    // No response: LOOKUP lasts exactly TIMEOUT cycles and counts a miss.
    begin
      int n = 0;
      stall = 1'b1;
      e = '{cls: 6'd3, cyc: 32'd33, hit: 1'b1, anom: 1'b0, slow: 1'b0, fast: 1'b0, lat: 0};
      send_one(e, acc);
      drop_valid();
      for (int k = 0; k < 100; k++) begin
        @(negedge clk);
        if (sig_req) n++;
        else if (n > 0) break;
      end
      stall = 1'b0;
      check("tmo_lookup_cycles", n, 32'd16);
      m_miss++;
      drain("tmo");
      check_model("tmo");
    end
`else
    // No timer: LOOKUP waits as long as the DB does.
    stall = 1'b1;
    e = '{cls: 6'd3, cyc: 32'd33, hit: 1'b1, anom: 1'b0, slow: 1'b0, fast: 1'b0, lat: 0};
    send_one(e, acc);
    drop_valid();
    repeat (40) @(negedge clk);
    check("wait_sig_req_held", {31'd0, sig_req}, 32'd1);
    stall = 1'b0;
    drain("wait");
    model(e);
    check_model("wait");
`endif

    check("total_cmp_enables", n_cmp_en, m_chk);
    check("final_exp_q_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
